// File: rtl/twos_serial_if.sv
// Word-in / bit-out handshake bundle for the twos_serial stage.
// slave is the stage's view; master is the upstream/downstream environment's view.
interface twos_serial_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_inc;
    logic             sout_valid;
    logic             sout_ready;
    logic             sout_bit;
    logic             sout_last;
    logic             sout_cout;

    modport slave (
        input  in_valid, in_data, in_inc, sout_ready,
        output in_ready, sout_valid, sout_bit, sout_last, sout_cout
    );

    modport master (
        output in_valid, in_data, in_inc, sout_ready,
        input  in_ready, sout_valid, sout_bit, sout_last, sout_cout
    );
endinterface

// File: rtl/twos_serial.sv
// Captures a ones-complement word, adds optional +1 bit-serially and streams it LSB first.
// Define TWOS_SERIAL_PAR_EN to add the par_data/par_valid parallel result collector.
`ifndef ONES_WIDTH
`define ONES_WIDTH 8
`endif

module twos_serial #(
    parameter int WIDTH = `ONES_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    twos_serial_if.slave     bus
`ifdef TWOS_SERIAL_PAR_EN
    ,
    output logic [WIDTH-1:0] par_data,
    output logic             par_valid
`endif
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic shifting;
    logic last;
    logic res_bit;
    logic beat;

    assign shifting = (state == SHIFT);
    assign last     = shifting && (cnt == CW'(WIDTH - 1));
    assign res_bit  = shreg[0] ^ carry;
    assign beat     = shifting && bus.sout_ready;

    assign bus.in_ready   = !shifting;
    assign bus.sout_valid = shifting;
    assign bus.sout_bit   = shifting ? res_bit : 1'b0;
    assign bus.sout_last  = last;
    assign bus.sout_cout  = last ? (shreg[0] & carry) : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            shreg <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (!shifting) begin
            if (bus.in_valid) begin
                shreg <= bus.in_data;
                carry <= bus.in_inc;
                cnt   <= '0;
                state <= SHIFT;
            end
        end else if (beat) begin
            shreg <= shreg >> 1;
            carry <= shreg[0] & carry;
            // cnt is parked at zero on exit so it never wraps
            if (last) begin
                cnt   <= '0;
                state <= IDLE;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

`ifdef TWOS_SERIAL_PAR_EN
    logic [WIDTH-1:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            par_data  <= '0;
            par_valid <= 1'b0;
        end else begin
            par_valid <= 1'b0;
            if (beat) begin
                col <= {res_bit, col[WIDTH-1:1]};
                if (last) begin
                    par_data  <= {res_bit, col[WIDTH-1:1]};
                    par_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_twos_serial.sv
// Self-checking bench for twos_serial: directed words plus random words against an arithmetic model.
module tb_twos_serial;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    twos_serial_if #(.WIDTH(W)) bus ();

`ifdef TWOS_SERIAL_PAR_EN
    logic [W-1:0] par_data;
    logic         par_valid;
`endif

    twos_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef TWOS_SERIAL_PAR_EN
        ,
        .par_data  (par_data),
        .par_valid (par_valid)
`endif
    );

    int n_assert = 0;
    int n_fail   = 0;
    logic [W-1:0] last_par = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        chk({tag, "_sout_valid"}, 32'(bus.sout_valid), 0);
        chk({tag, "_sout_bit"}, 32'(bus.sout_bit), 0);
        chk({tag, "_sout_last"}, 32'(bus.sout_last), 0);
        chk({tag, "_sout_cout"}, 32'(bus.sout_cout), 0);
`ifdef TWOS_SERIAL_PAR_EN
        chk({tag, "_par_valid"}, 32'(par_valid), 0);
        chk({tag, "_par_data"}, 32'(par_data), 0);
`endif
    endtask

    // Sends one word and checks every emitted bit against (d + inc) mod 2^W with carry out.
    // stall_bit/stall_len force a stall before that bit; rnd adds random stalls and in_valid noise;
    // abort_at >= 0 pulls reset after that many beats.
    task automatic do_word(input logic [W-1:0] d, input logic inc, input int stall_bit,
                           input int stall_len, input bit rnd, input int abort_at);
        logic [W:0] sum;
        int st;
        sum = {1'b0, d} + {{W{1'b0}}, inc};
        chk("accept_in_ready", 32'(bus.in_ready), 1);
        chk("accept_sout_valid", 32'(bus.sout_valid), 0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_inc   = inc;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = rnd ? 1'($urandom) : 1'b0;
        bus.in_data  = W'($urandom);
        bus.in_inc   = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk_reset_outputs("abort");
                last_par = '0;
                @(negedge clk);
                bus.in_valid = 1'b0;
                rst_n = 1'b1;
                @(negedge clk);
                return;
            end
            st = rnd ? int'($urandom_range(0, 2)) : 0;
            if (i == stall_bit) st = stall_len;
            for (int s = 0; s < st; s++) begin
                bus.sout_ready = 1'b0;
                chk("stall_valid", 32'(bus.sout_valid), 1);
                chk("stall_bit", 32'(bus.sout_bit), 32'(sum[i]));
                chk("stall_last", 32'(bus.sout_last), 32'(i == W - 1));
                chk("stall_in_ready", 32'(bus.in_ready), 0);
                @(posedge clk);
                @(negedge clk);
            end
            bus.sout_ready = 1'b1;
            chk("shift_valid", 32'(bus.sout_valid), 1);
            chk("shift_in_ready", 32'(bus.in_ready), 0);
            chk("shift_bit", 32'(bus.sout_bit), 32'(sum[i]));
            chk("shift_last", 32'(bus.sout_last), 32'(i == W - 1));
            chk("shift_cout", 32'(bus.sout_cout), (i == W - 1) ? 32'(sum[W]) : 0);
`ifdef TWOS_SERIAL_PAR_EN
            chk("shift_par_valid", 32'(par_valid), 0);
            chk("shift_par_hold", 32'(par_data), 32'(last_par));
`endif
            @(posedge clk);
            @(negedge clk);
        end
        bus.in_valid   = 1'b0;
        bus.sout_ready = 1'b0;
        chk("done_in_ready", 32'(bus.in_ready), 1);
        chk("done_sout_valid", 32'(bus.sout_valid), 0);
        last_par = sum[W-1:0];
`ifdef TWOS_SERIAL_PAR_EN
        chk("done_par_valid", 32'(par_valid), 1);
        chk("done_par_data", 32'(par_data), 32'(last_par));
`endif
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_inc     = 1'b0;
        bus.sout_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset_idle");

        do_word(8'hFA, 1'b1, -1, 0, 1'b0, -1);
        do_word(8'hFF, 1'b1, -1, 0, 1'b0, -1);
        do_word(8'hA5, 1'b0, -1, 0, 1'b0, -1);
        do_word(8'h3C, 1'b1, -1, 0, 1'b0, -1);
        do_word(8'h5A, 1'b0, 2, 3, 1'b0, -1);
`ifdef TWOS_SERIAL_PAR_EN
        @(negedge clk);
        chk("par_pulse_drop", 32'(par_valid), 0);
        chk("par_data_hold", 32'(par_data), 32'h5A);
`endif
        do_word(8'h77, 1'b1, -1, 0, 1'b0, 3);
        do_word(8'h01, 1'b1, -1, 0, 1'b0, -1);

        repeat (40) begin
            logic [W-1:0] d;
            logic inc;
            d   = W'($urandom);
            inc = 1'($urandom);
            if ($urandom_range(0, 7) == 0) d = '1;
            do_word(d, inc, -1, 0, 1'b1, -1);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                chk("gap_in_ready", 32'(bus.in_ready), 1);
                chk("gap_sout_valid", 32'(bus.sout_valid), 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
